// File: rtl/mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder_if
// Description : Two-port address/store request bus between the schedule
//               multiplexer (master) and the memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_responder_if #(
    parameter int DATA_W = 32,
    parameter int BUS_W  = 32
);
    logic [1:0]        state;
    logic [BUS_W-1:0]  add_1;
    logic [BUS_W-1:0]  add_2;
    logic [DATA_W-1:0] store_val_1;
    logic [DATA_W-1:0] store_val_2;
    logic              store_1;
    logic              store_2;

    modport master (
        output state, add_1, add_2, store_val_1, store_val_2, store_1, store_2
    );

    modport slave (
        input  state, add_1, add_2, store_val_1, store_val_2, store_1, store_2
    );
endinterface
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : mem_responder
// Description : 1024-word data memory behind the two-port schedule bus.
//               Performs port writes, returns loads into named result
//               registers with one-cycle valid pulses, flags bad addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int BUS_W  = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    mem_responder_if.slave         bus,
    output logic [DATA_W-1:0]      load_val_0,
    output logic [DATA_W-1:0]      load_val_16,
    output logic [DATA_W-1:0]      load_val_23,
    output logic                   ld_valid_0,
    output logic                   ld_valid_16,
    output logic                   ld_valid_23,
    output logic                   addr_err
);

    localparam int         c_DEPTH    = 1 << ADDR_W;
    localparam logic [1:0] c_ST_IDLE  = 2'b00;  // no access
    localparam logic [1:0] c_ST_WR_RD = 2'b01;  // p1 write, p2 read -> load_val_0
    localparam logic [1:0] c_ST_RD_RD = 2'b10;  // p1 -> load_val_16, p2 -> load_val_23
    localparam logic [1:0] c_ST_WR_WR = 2'b11;  // both ports write

    logic [1:0]        r_state_q;
    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic              w_ok_1;
    logic              w_ok_2;
    logic [ADDR_W-1:0] w_idx_1;
    logic [ADDR_W-1:0] w_idx_2;
    logic              w_wr_req_1;
    logic              w_wr_req_2;
    logic              w_rd_0;
    logic              w_rd_pair;
    logic              w_we_1;
    logic              w_we_2;
    logic              w_err;
    logic [DATA_W-1:0] w_rdata_1;
    logic [DATA_W-1:0] w_rdata_2;

    // Address range check: upper bus bits must be zero for a legal index.
    assign w_ok_1  = (bus.add_1[BUS_W-1:ADDR_W] == '0);
    assign w_ok_2  = (bus.add_2[BUS_W-1:ADDR_W] == '0);
    assign w_idx_1 = bus.add_1[ADDR_W-1:0];
    assign w_idx_2 = bus.add_2[ADDR_W-1:0];

    // Slot decode on the delayed state, which is aligned with the bus contents.
    assign w_wr_req_1 = bus.store_1 &&
                        ((r_state_q == c_ST_WR_RD) || (r_state_q == c_ST_WR_WR));
    assign w_wr_req_2 = bus.store_2 && (r_state_q == c_ST_WR_WR);
    assign w_rd_0     = (r_state_q == c_ST_WR_RD);
    assign w_rd_pair  = (r_state_q == c_ST_RD_RD);

    assign w_we_1 = w_wr_req_1 && w_ok_1;
    assign w_we_2 = w_wr_req_2 && w_ok_2;

    assign w_err = (w_wr_req_1 && !w_ok_1) ||
                   (w_wr_req_2 && !w_ok_2) ||
                   ((w_rd_0 || w_rd_pair) && !w_ok_2) ||
                   (w_rd_pair && !w_ok_1);

    // Out-of-range reads return zero; in-range reads see pre-write contents.
    assign w_rdata_1 = w_ok_1 ? r_mem[w_idx_1] : '0;
    assign w_rdata_2 = w_ok_2 ? r_mem[w_idx_2] : '0;

    // Schedule state tracker, one edge behind the multiplexer's input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= c_ST_IDLE;
        end else begin
            r_state_q <= bus.state;
        end
    end

    // Memory writes; port 2 is written last so it wins on a same-address pair.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_we_1) begin
                r_mem[w_idx_1] <= bus.store_val_1;
            end
            if (w_we_2) begin
                r_mem[w_idx_2] <= bus.store_val_2;
            end
        end
    end

    // Result registers, valid pulses and sticky address error.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_val_0  <= '0;
            load_val_16 <= '0;
            load_val_23 <= '0;
            ld_valid_0  <= 1'b0;
            ld_valid_16 <= 1'b0;
            ld_valid_23 <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            ld_valid_0  <= w_rd_0;
            ld_valid_16 <= w_rd_pair;
            ld_valid_23 <= w_rd_pair;
            if (w_rd_0) begin
                load_val_0 <= w_rdata_2;
            end
            if (w_rd_pair) begin
                load_val_16 <= w_rdata_1;
                load_val_23 <= w_rdata_2;
            end
            if (w_err) begin
                addr_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_responder
// Description : Self-checking bench for mem_responder: vector table of bus
//               operations plus hand sequences for reset and pipelining.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic [31:0] load_val_0;
    logic [31:0] load_val_16;
    logic [31:0] load_val_23;
    logic        ld_valid_0;
    logic        ld_valid_16;
    logic        ld_valid_23;
    logic        addr_err;

    int n_checks;
    int n_fail;

    mem_responder_if #(.DATA_W(32), .BUS_W(32)) bus ();

    mem_responder #(
        .DATA_W (32),
        .ADDR_W (10),
        .BUS_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .load_val_0  (load_val_0),
        .load_val_16 (load_val_16),
        .load_val_23 (load_val_23),
        .ld_valid_0  (ld_valid_0),
        .ld_valid_16 (ld_valid_16),
        .ld_valid_23 (ld_valid_23),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  st;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        w1;
        logic [31:0] a2;
        logic [31:0] d2;
        logic        w2;
        logic        v0;
        logic        v16;
        logic        v23;
        logic [31:0] l0;
        logic [31:0] l16;
        logic [31:0] l23;
        logic        err;
    } vec_t;

    localparam int c_NVEC = 18;
    vec_t vecs [c_NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic set_bus(input logic [31:0] a1, input logic [31:0] d1, input logic w1,
                           input logic [31:0] a2, input logic [31:0] d2, input logic w2);
        bus.add_1       = a1;
        bus.store_val_1 = d1;
        bus.store_1     = w1;
        bus.add_2       = a2;
        bus.store_val_2 = d2;
        bus.store_2     = w2;
    endtask

    // Called at a negedge: present state, then the bus one cycle later, then
    // return at the negedge where the access result is visible.
    task automatic apply(input vec_t v);
        bus.state = v.st;
        @(negedge clk);
        bus.state = 2'b00;
        set_bus(v.a1, v.d1, v.w1, v.a2, v.d2, v.w2);
        @(negedge clk);
    endtask

    task automatic check_outputs(input string tag, input logic v0, input logic v16,
                                 input logic v23, input logic [31:0] l0,
                                 input logic [31:0] l16, input logic [31:0] l23,
                                 input logic err);
        check({tag, " ld_valid_0"},  {31'd0, ld_valid_0},  {31'd0, v0});
        check({tag, " ld_valid_16"}, {31'd0, ld_valid_16}, {31'd0, v16});
        check({tag, " ld_valid_23"}, {31'd0, ld_valid_23}, {31'd0, v23});
        check({tag, " load_val_0"},  load_val_0,  l0);
        check({tag, " load_val_16"}, load_val_16, l16);
        check({tag, " load_val_23"}, load_val_23, l23);
        check({tag, " addr_err"},    {31'd0, addr_err},    {31'd0, err});
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //            st     a1          d1           w1    a2           d2           w2    v0 v16 v23  l0     l16          l23          err
        vecs[0]  = '{2'b11, 32'd5,      32'hA5A50001, 1'b1, 32'd6,       32'h2,       1'b1, 0, 0, 0, 32'h0,  32'h0,       32'h0,       0};
        vecs[1]  = '{2'b10, 32'd5,      32'h0,        1'b0, 32'd6,       32'h0,       1'b0, 0, 1, 1, 32'h0,  32'hA5A50001, 32'h2,       0};
        vecs[2]  = '{2'b11, 32'd7,      32'h11,       1'b1, 32'd7,       32'h99,      1'b0, 0, 0, 0, 32'h0,  32'hA5A50001, 32'h2,       0};
        vecs[3]  = '{2'b01, 32'd7,      32'h22,       1'b1, 32'd7,       32'h0,       1'b0, 1, 0, 0, 32'h11, 32'hA5A50001, 32'h2,       0};
        vecs[4]  = '{2'b10, 32'd7,      32'h0,        1'b0, 32'd7,       32'h0,       1'b0, 0, 1, 1, 32'h11, 32'h22,       32'h22,      0};
        vecs[5]  = '{2'b11, 32'd9,      32'h33,       1'b1, 32'd9,       32'h44,      1'b1, 0, 0, 0, 32'h11, 32'h22,       32'h22,      0};
        vecs[6]  = '{2'b10, 32'd9,      32'h0,        1'b0, 32'd5,       32'h0,       1'b0, 0, 1, 1, 32'h11, 32'h44,       32'hA5A50001, 0};
        vecs[7]  = '{2'b11, 32'd3,      32'h0C,       1'b1, 32'd4,       32'h0D,      1'b1, 0, 0, 0, 32'h11, 32'h44,       32'hA5A50001, 0};
        vecs[8]  = '{2'b00, 32'd3,      32'hFF,       1'b1, 32'd4,       32'hFF,      1'b1, 0, 0, 0, 32'h11, 32'h44,       32'hA5A50001, 0};
        vecs[9]  = '{2'b10, 32'd3,      32'hEE,       1'b1, 32'd4,       32'hEE,      1'b1, 0, 1, 1, 32'h11, 32'h0C,       32'h0D,      0};
        vecs[10] = '{2'b01, 32'd3,      32'h77,       1'b0, 32'd3,       32'h0,       1'b0, 1, 0, 0, 32'h0C, 32'h0C,       32'h0D,      0};
        vecs[11] = '{2'b01, 32'd4,      32'h0E,       1'b1, 32'd4,       32'h0,       1'b0, 1, 0, 0, 32'h0D, 32'h0C,       32'h0D,      0};
        vecs[12] = '{2'b10, 32'd4,      32'h0,        1'b0, 32'd3,       32'h0,       1'b0, 0, 1, 1, 32'h0D, 32'h0E,       32'h0C,      0};
        vecs[13] = '{2'b11, 32'd0,      32'h1234,     1'b1, 32'd1,       32'h5678,    1'b1, 0, 0, 0, 32'h0D, 32'h0E,       32'h0C,      0};
        vecs[14] = '{2'b11, 32'd12,     32'hC0,       1'b1, 32'd13,      32'hD0,      1'b1, 0, 0, 0, 32'h0D, 32'h0E,       32'h0C,      0};
        vecs[15] = '{2'b11, 32'h400,    32'hBAD,      1'b1, 32'd1,       32'hDEAD,    1'b0, 0, 0, 0, 32'h0D, 32'h0E,       32'h0C,      1};
        vecs[16] = '{2'b10, 32'h400,    32'h0,        1'b0, 32'd0,       32'h0,       1'b0, 0, 1, 1, 32'h0D, 32'h0,        32'h1234,    1};
        vecs[17] = '{2'b10, 32'd1,      32'h0,        1'b0, 32'h80000001, 32'h0,      1'b0, 0, 1, 1, 32'h0D, 32'h5678,     32'h0,       1};

        rst       = 1'b1;
        bus.state = 2'b00;
        set_bus(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs("reset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);
        rst = 1'b0;

        for (int i = 0; i < c_NVEC; i++) begin
            apply(vecs[i]);
            check_outputs($sformatf("vec%0d", i), vecs[i].v0, vecs[i].v16, vecs[i].v23,
                          vecs[i].l0, vecs[i].l16, vecs[i].l23, vecs[i].err);
        end

        // Reset lands on the edge where a state-11 write to 12 would commit.
        bus.state = 2'b11;
        @(negedge clk);
        bus.state = 2'b00;
        set_bus(32'd12, 32'h55, 1'b1, 32'd13, 32'h66, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_bus(32'd0, 32'd0, 1'b0, 32'd0, 32'd0, 1'b0);
        check_outputs("midreset", 0, 0, 0, 32'h0, 32'h0, 32'h0, 0);

        // Contents written before reset survive; the dropped write left 12/13 alone.
        apply('{2'b10, 32'd12, 32'h0, 1'b0, 32'd5, 32'h0, 1'b0,
                0, 1, 1, 32'h0, 32'hC0, 32'hA5A50001, 0});
        check_outputs("post_rst_a", 0, 1, 1, 32'h0, 32'hC0, 32'hA5A50001, 0);
        apply('{2'b10, 32'd13, 32'h0, 1'b0, 32'd0, 32'h0, 1'b0,
                0, 1, 1, 32'h0, 32'hD0, 32'h1234, 0});
        check_outputs("post_rst_b", 0, 1, 1, 32'h0, 32'hD0, 32'h1234, 0);
        apply('{2'b10, 32'd9, 32'h0, 1'b0, 32'd1, 32'h0, 1'b0,
                0, 1, 1, 32'h0, 32'h44, 32'h5678, 0});
        check_outputs("post_rst_c", 0, 1, 1, 32'h0, 32'h44, 32'h5678, 0);

        // Back-to-back reads accepted on consecutive cycles.
        bus.state = 2'b10;
        @(negedge clk);
        bus.state = 2'b10;
        set_bus(32'd5, 32'd0, 1'b0, 32'd6, 32'd0, 1'b0);
        @(negedge clk);
        bus.state = 2'b00;
        set_bus(32'd9, 32'd0, 1'b0, 32'd12, 32'd0, 1'b0);
        check_outputs("pipe_1", 0, 1, 1, 32'h0, 32'hA5A50001, 32'h2, 0);
        @(negedge clk);
        check_outputs("pipe_2", 0, 1, 1, 32'h0, 32'h44, 32'hC0, 0);
        @(negedge clk);
        check_outputs("pipe_3", 0, 0, 0, 32'h0, 32'h44, 32'hC0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
